ppu_timing: RTL and testbench

- Dot/line timing generator for the Game Boy PPU.
- Counts dots and scanlines, decodes the PPU mode, and produces the outputs the memory map consumes: `ppu_oam_read_en`, `ppu_vram_read_en` and `ppu_read_mode` (CPU blocking and PPU read-port select).
- Drives the OAM-scan read address, and supplies the LY value, LYC compare, VBlank interrupt and STAT interrupt for the I/O register block.

---
 rtl/ppu_pkg.sv | 26 ++
 rtl/ppu_timing_if.sv | 29 ++
 rtl/ppu_stat_irq.sv | 36 +++
 rtl/ppu_timing.sv | 78 +++++++
 tb/tb_ppu_timing.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared types and timing constants for the PPU dot/line timing block.
package ppu_pkg;

  localparam int DOTS_PER_LINE   = 456;
  localparam int LINES_PER_FRAME = 154;
  localparam int VISIBLE_LINES   = 144;
  localparam int OAM_DOTS        = 80;
  localparam int XFER_DOTS       = 172;

  typedef enum logic [1:0] {
    PPU_HBLANK   = 2'd0,
    PPU_VBLANK   = 2'd1,
    PPU_OAM_SCAN = 2'd2,
    PPU_XFER     = 2'd3
  } ppu_mode_t;

  // LCD off reads as HBlank so every enable derived from the mode drops.
  function automatic ppu_mode_t decode_mode(logic on, logic [7:0] ly, logic [8:0] dot);
    if (!on)                                   return PPU_HBLANK;
    if (ly >= 8'(VISIBLE_LINES))               return PPU_VBLANK;
    if (dot < 9'(OAM_DOTS))                    return PPU_OAM_SCAN;
    if (dot < 9'(OAM_DOTS + XFER_DOTS))        return PPU_XFER;
    return PPU_HBLANK;
  endfunction

endpackage

// File: rtl/ppu_timing_if.sv
// Control inputs and timing/status outputs of the PPU timing generator.
interface ppu_timing_if;
  logic       tick;
  logic       lcd_en;
  logic [7:0] lyc;
  logic [3:0] stat_sel;
  logic [7:0] ly;
  logic [8:0] dot;
  logic [1:0] mode;
  logic       lyc_match;
  logic       ppu_oam_read_en;
  logic       ppu_vram_read_en;
  logic       ppu_read_mode;
  logic [7:0] oam_scan_addr;
  logic       vblank_irq;
  logic       stat_irq;

  modport master (
    output tick, lcd_en, lyc, stat_sel,
    input  ly, dot, mode, lyc_match, ppu_oam_read_en, ppu_vram_read_en,
           ppu_read_mode, oam_scan_addr, vblank_irq, stat_irq
  );

  modport slave (
    input  tick, lcd_en, lyc, stat_sel,
    output ly, dot, mode, lyc_match, ppu_oam_read_en, ppu_vram_read_en,
           ppu_read_mode, oam_scan_addr, vblank_irq, stat_irq
  );
endinterface

// File: rtl/ppu_stat_irq.sv
// STAT interrupt: ORs the enabled sources into one line and pulses on its rising edge.
module ppu_stat_irq
  import ppu_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      lcd_on_i,
  input  logic [3:0] sel_i,
  input  ppu_mode_t mode_i,
  input  logic      lyc_match_i,
  output logic      stat_irq_o
);

  logic stat_line;
  logic stat_line_q;
  logic stat_irq_q;

  // A line that stays high across mode changes must not retrigger.
  assign stat_line = lcd_on_i & ((sel_i[0] & (mode_i == PPU_HBLANK))   |
                                 (sel_i[1] & (mode_i == PPU_VBLANK))   |
                                 (sel_i[2] & (mode_i == PPU_OAM_SCAN)) |
                                 (sel_i[3] & lyc_match_i));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_line_q <= 1'b0;
      stat_irq_q  <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
      stat_irq_q  <= stat_line & ~stat_line_q;
    end
  end

  assign stat_irq_o = stat_irq_q;

endmodule

// File: rtl/ppu_timing.sv
// Game Boy PPU dot/scanline counter, mode decode, memory-port enables and IRQs.
module ppu_timing
  import ppu_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  ppu_timing_if.slave   bus
);

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic       lcd_on_q;
  logic       vblank_q, vblank_d;
  logic       line_end, frame_end;
  logic       lyc_match;
  ppu_mode_t  mode;

  assign line_end  = (dot_q == 9'(DOTS_PER_LINE - 1));
  assign frame_end = (ly_q == 8'(LINES_PER_FRAME - 1));

  // Dropping lcd_en clears the counters on the very next clock.
  always_comb begin
    dot_d    = dot_q;
    ly_d     = ly_q;
    vblank_d = 1'b0;
    if (!bus.lcd_en || !lcd_on_q) begin
      dot_d = '0;
      ly_d  = '0;
    end else if (bus.tick) begin
      if (line_end) begin
        dot_d    = '0;
        ly_d     = frame_end ? 8'd0 : ly_q + 8'd1;
        vblank_d = (ly_q == 8'(VISIBLE_LINES - 1));
      end else begin
        dot_d = dot_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dot_q    <= '0;
      ly_q     <= '0;
      lcd_on_q <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      dot_q    <= dot_d;
      ly_q     <= ly_d;
      lcd_on_q <= bus.lcd_en;
      vblank_q <= vblank_d;
    end
  end

  assign mode      = decode_mode(lcd_on_q, ly_q, dot_q);
  assign lyc_match = lcd_on_q && (ly_q == bus.lyc);

  assign bus.ly               = ly_q;
  assign bus.dot              = dot_q;
  assign bus.mode             = mode;
  assign bus.lyc_match        = lyc_match;
  assign bus.ppu_oam_read_en  = (mode == PPU_OAM_SCAN) || (mode == PPU_XFER);
  assign bus.ppu_vram_read_en = (mode == PPU_XFER);
  assign bus.ppu_read_mode    = (mode != PPU_OAM_SCAN);
  // Even dot -> Y byte, odd dot -> X byte of sprite dot>>1.
  assign bus.oam_scan_addr    = (mode == PPU_OAM_SCAN) ? {dot_q[6:1], 1'b0, dot_q[0]} : 8'd0;
  assign bus.vblank_irq       = vblank_q;

  ppu_stat_irq u_stat (
    .clock       (clock),
    .reset       (reset),
    .lcd_on_i    (lcd_on_q),
    .sel_i       (bus.stat_sel),
    .mode_i      (mode),
    .lyc_match_i (lyc_match),
    .stat_irq_o  (bus.stat_irq)
  );

endmodule

// File: tb/tb_ppu_timing.sv
// Self-checking bench for ppu_timing: frame-position reference model plus directed pins.
module tb_ppu_timing;

  localparam int LINE  = 456;
  localparam int FRAME = 456 * 154;

  logic clock = 1'b0;
  logic reset = 1'b1;
  ppu_timing_if bus();

  ppu_timing dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: linear position within the frame.
  int pos   = 0;
  bit on    = 1'b0;
  bit sl_q  = 1'b0;
  bit e_vb  = 1'b0;
  bit e_st  = 1'b0;
  int old_l = 0;
  bit ln    = 1'b0;

  function automatic int m_mode(bit o, int p);
    int l = p / LINE;
    int d = p % LINE;
    if (!o)      return 0;
    if (l >= 144) return 1;
    if (d < 80)  return 2;
    if (d < 252) return 3;
    return 0;
  endfunction

  function automatic bit m_line(bit o, int p, logic [3:0] sel, logic [7:0] lyc);
    int m = m_mode(o, p);
    bit match = o && ((p / LINE) == int'(lyc));
    return o && ((sel[0] && m == 0) || (sel[1] && m == 1) || (sel[2] && m == 2) || (sel[3] && match));
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pos = 0; on = 0; sl_q = 0; e_vb = 0; e_st = 0;
    end else begin
      ln   = m_line(on, pos, bus.stat_sel, bus.lyc);
      e_st = ln && !sl_q;
      sl_q = ln;
      old_l = pos / LINE;
      if (!bus.lcd_en || !on) pos = 0;
      else if (bus.tick) pos = (pos + 1) % FRAME;
      e_vb = on && old_l == 143 && (pos / LINE) == 144;
      on   = bus.lcd_en;
    end
  end

  // Per-cycle compare of every output against the model.
  logic [32:0] act_v, exp_v;
  int em, ed;
  always @(negedge clock) begin
    if (!reset) begin
      em = m_mode(on, pos);
      ed = pos % LINE;
      exp_v = {8'(pos / LINE), 9'(ed), 2'(em), on && ((pos / LINE) == int'(bus.lyc)),
               (em == 2 || em == 3), (em == 3), (em != 2),
               8'((em == 2) ? (4 * (ed / 2) + ed % 2) : 0), e_vb, e_st};
      act_v = {bus.ly, bus.dot, bus.mode, bus.lyc_match, bus.ppu_oam_read_en,
               bus.ppu_vram_read_en, bus.ppu_read_mode, bus.oam_scan_addr,
               bus.vblank_irq, bus.stat_irq};
      chk("model", 64'(act_v), 64'(exp_v));
    end
  end

  // Event counters for the directed literal checks.
  int st_cnt = 0, vb_cnt = 0, m_cnt = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.stat_irq)   st_cnt++;
      if (bus.vblank_irq) vb_cnt++;
      if (bus.lyc_match)  m_cnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_pos(int l, int d, int maxc, string nm);
    int n = 0;
    while (!(int'(bus.ly) == l && int'(bus.dot) == d) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      n_chk++;
      $display("FAIL %s timeout actual=ly%0d/dot%0d required=ly%0d/dot%0d", nm, bus.ly, bus.dot, l, d);
    end
  endtask

  task automatic chk_zero_outputs(string nm);
    chk({nm, "_ly"},   bus.ly, 0);
    chk({nm, "_dot"},  bus.dot, 0);
    chk({nm, "_mode"}, bus.mode, 0);
    chk({nm, "_oen"},  bus.ppu_oam_read_en, 0);
    chk({nm, "_ven"},  bus.ppu_vram_read_en, 0);
    chk({nm, "_addr"}, bus.oam_scan_addr, 0);
    chk({nm, "_vb"},   bus.vblank_irq, 0);
    chk({nm, "_st"},   bus.stat_irq, 0);
    chk({nm, "_lm"},   bus.lyc_match, 0);
  endtask

  initial begin
    bus.tick = 1'b1; bus.lcd_en = 1'b0; bus.lyc = 8'd5; bus.stat_sel = 4'b1000;
    #3;
    chk_zero_outputs("reset");
    step();
    reset = 1'b0;
    step();
    bus.lcd_en = 1'b1;
    st_cnt = 0; m_cnt = 0;

    wait_pos(0, 7, 20, "w_dot7");
    chk("d7_mode", bus.mode, 2);
    chk("d7_addr", bus.oam_scan_addr, 13);
    chk("d7_rmode", bus.ppu_read_mode, 0);
    wait_pos(0, 80, 200, "w_dot80");
    chk("d80_mode", bus.mode, 3);
    chk("d80_oen", bus.ppu_oam_read_en, 1);
    chk("d80_ven", bus.ppu_vram_read_en, 1);
    chk("d80_rmode", bus.ppu_read_mode, 1);
    wait_pos(0, 252, 300, "w_dot252");
    chk("d252_mode", bus.mode, 0);
    chk("d252_oen", bus.ppu_oam_read_en, 0);
    chk("d252_ven", bus.ppu_vram_read_en, 0);

    // LYC=5 source only: single pulse when line 5 starts.
    wait_pos(5, 300, 3000, "w_ly5");
    chk("lyc_pulses", st_cnt, 1);
    bus.stat_sel = 4'b0101;
    st_cnt = 0;
    wait_pos(6, 0, 300, "w_ly6");
    chk("lyc_match_len", m_cnt, 456);
    wait_pos(9, 0, 2000, "w_ly9");
    chk("hblank_oam_pulses", st_cnt, 3);

    wait_pos(10, 100, 1000, "w_ly10");
    bus.lcd_en = 1'b0;
    step(); step();
    chk("off_ly", bus.ly, 0);
    chk("off_dot", bus.dot, 0);
    chk("off_mode", bus.mode, 0);

    bus.lcd_en = 1'b1;
    bus.stat_sel = 4'b0010;
    vb_cnt = 0;
    wait_pos(144, 0, 70000, "w_ly144");
    chk("vbl_mode", bus.mode, 1);
    wait_pos(0, 0, 5000, "w_wrap");
    chk("wrap_mode", bus.mode, 2);
    chk("wrap_vb_cnt", vb_cnt, 1);

    bus.tick = 1'b0;
    repeat (10) step();
    chk("frz_ly", bus.ly, 0);
    chk("frz_dot", bus.dot, 0);

    for (int i = 0; i < 3000; i++) begin
      step();
      bus.tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) bus.lyc = 8'($urandom_range(0, 8));
      if ($urandom_range(0, 29) == 0) bus.stat_sel = 4'($urandom);
      if (!bus.lcd_en) bus.lcd_en = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 699) == 0) bus.lcd_en = 1'b0;
    end

    bus.lcd_en = 1'b1; bus.tick = 1'b1;
    repeat (600) step();
    reset = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    step();
    reset = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
